vector_mac_engine: RTL and testbench

VECTOR_MAC_ENGINE -- requirements
Module: vector_mac_engine

---
 rtl/vector_mac_pkg.sv | 19 +
 rtl/vec_lane_mul.sv | 19 +
 rtl/vector_mac_engine.sv | 146 ++++++++++++++
 tb/tb_vector_mac_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mac_pkg.sv
// rtl/vector_mac_pkg.sv - shared encodings for the vector multiply-accumulate engine
package vector_mac_pkg;

    typedef enum logic {
        MODE_ELEMWISE = 1'b0,
        MODE_DOT      = 1'b1
    } mac_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mac_state_e;

    function automatic int acc_width(input int data_width, input int vector_size);
        return 2 * data_width + $clog2(vector_size);
    endfunction

endpackage

// File: rtl/vec_lane_mul.sv
// rtl/vec_lane_mul.sv - one unsigned multiplier lane with saturation clamp and overflow flag
module vec_lane_mul #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic                    saturate,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic [DATA_WIDTH-1:0]   clamped,
    output logic                    overflow
);

    always_comb begin
        product  = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        overflow = |product[2*DATA_WIDTH-1:DATA_WIDTH];
        clamped  = (saturate && overflow) ? {DATA_WIDTH{1'b1}} : product[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/vector_mac_engine.sv
// rtl/vector_mac_engine.sv - multi-beat element-wise multiply / dot-product engine
module vector_mac_engine
    import vector_mac_pkg::*;
#(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         mode,
    input  logic                                         saturate,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]            vector_a,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]            vector_b,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0]            result,
    output logic [2*DATA_WIDTH+$clog2(VECTOR_SIZE)-1:0]  dot_result,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow
);

    localparam int BEATS     = VECTOR_SIZE / LANES;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, VECTOR_SIZE);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VEC_W     = DATA_WIDTH * VECTOR_SIZE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (VECTOR_SIZE % LANES != 0) begin : g_bad_lanes
            $error("vector_mac_engine: VECTOR_SIZE must be a multiple of LANES");
        end
    endgenerate

    mac_state_e              state_q;
    mac_state_e              state_d;
    logic                    accept;
    logic [BEAT_W-1:0]       beat_q;
    logic [VEC_W-1:0]        a_q;
    logic [VEC_W-1:0]        b_q;
    mac_mode_e               mode_q;
    logic                    sat_q;

    logic [DATA_WIDTH-1:0]   lane_a       [LANES];
    logic [DATA_WIDTH-1:0]   lane_b       [LANES];
    logic [DATA_WIDTH-1:0]   lane_clamped [LANES];
    logic [2*DATA_WIDTH-1:0] lane_prod    [LANES];
    logic [LANES-1:0]        lane_ovf;
    logic [ACC_WIDTH-1:0]    beat_sum;

    // Each beat feeds the lanes a contiguous group of LANES elements.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = a_q[(int'(beat_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH];
            lane_b[l] = b_q[(int'(beat_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            vec_lane_mul #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_lane (
                .a       (lane_a[g]),
                .b       (lane_b[g]),
                .saturate(sat_q),
                .product (lane_prod[g]),
                .clamped (lane_clamped[g]),
                .overflow(lane_ovf[g])
            );
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + ACC_WIDTH'(lane_prod[l]);
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q == ST_COMPUTE) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Products land directly in the output registers; they hold after DONE until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= MODE_ELEMWISE;
            sat_q      <= 1'b0;
            result     <= '0;
            dot_result <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            beat_q     <= '0;
            a_q        <= vector_a;
            b_q        <= vector_b;
            mode_q     <= mac_mode_e'(mode);
            sat_q      <= saturate;
            result     <= '0;
            dot_result <= '0;
            overflow   <= 1'b0;
        end else if (state_q == ST_COMPUTE) begin
            beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            if (mode_q == MODE_DOT) begin
                dot_result <= dot_result + beat_sum;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    result[(int'(beat_q) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] <= lane_clamped[l];
                end
                if (|lane_ovf) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mac_engine.sv
// tb/tb_vector_mac_engine.sv - self-checking bench for vector_mac_engine at LANES=2, 1 and 8
module tb_vector_mac_engine;

    localparam int VS = 8;
    localparam int DW = 16;
    localparam int AW = 35;
    localparam int VW = VS * DW;

    typedef int unsigned elem_arr_t[VS];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          saturate = 1'b0;
    logic [VW-1:0] vector_a = '0;
    logic [VW-1:0] vector_b = '0;

    logic [VW-1:0] res_w  [3];
    logic [AW-1:0] dot_w  [3];
    logic          busy_w [3];
    logic          done_w [3];
    logic          ovf_w  [3];

    int n_checks = 0;
    int n_fail   = 0;
    int beats   [3] = '{4, 8, 1};
    int lat_ref [3] = '{5, 9, 2};

    always #5 clk = ~clk;

    vector_mac_engine u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .saturate(saturate),
        .vector_a(vector_a), .vector_b(vector_b), .result(res_w[0]), .dot_result(dot_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .overflow(ovf_w[0])
    );

    vector_mac_engine #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .saturate(saturate),
        .vector_a(vector_a), .vector_b(vector_b), .result(res_w[1]), .dot_result(dot_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .overflow(ovf_w[1])
    );

    vector_mac_engine #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .saturate(saturate),
        .vector_a(vector_a), .vector_b(vector_b), .result(res_w[2]), .dot_result(dot_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .overflow(ovf_w[2])
    );

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack8(input elem_arr_t e);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < VS; i++) v[DW*i +: DW] = DW'(e[i]);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input int unsigned val);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < VS; i++) v[DW*i +: DW] = DW'(val);
        return v;
    endfunction

    // Reference arithmetic: whole-vector result computed element by element.
    task automatic model_op(input logic md, input logic st, input logic [VW-1:0] a,
                            input logic [VW-1:0] b, output logic [VW-1:0] r,
                            output logic [AW-1:0] d, output logic o);
        longint unsigned p;
        r = '0;
        d = '0;
        o = 1'b0;
        for (int i = 0; i < VS; i++) begin
            p = 64'(a[DW*i +: DW]) * 64'(b[DW*i +: DW]);
            if (md) begin
                d = d + AW'(p);
            end else begin
                if (p > 64'd65535) o = 1'b1;
                r[DW*i +: DW] = (st && p > 64'd65535) ? 16'hFFFF : p[15:0];
            end
        end
    endtask

    // Per instance: edges since the accepting edge (-1 when idle) and the final outputs owed.
    int            k_m   [3] = '{-1, -1, -1};
    logic [VW-1:0] m_res [3] = '{default: '0};
    logic [AW-1:0] m_dot [3] = '{default: '0};
    logic          m_ovf [3] = '{default: 1'b0};

    always @(posedge clk or negedge rst_n) begin
        logic [VW-1:0] r;
        logic [AW-1:0] d;
        logic          o;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                k_m[i]   <= -1;
                m_res[i] <= '0;
                m_dot[i] <= '0;
                m_ovf[i] <= 1'b0;
            end
        end else begin
            model_op(mode, saturate, vector_a, vector_b, r, d, o);
            for (int i = 0; i < 3; i++) begin
                if (k_m[i] < 0) begin
                    if (start) begin
                        k_m[i]   <= 0;
                        m_res[i] <= r;
                        m_dot[i] <= d;
                        m_ovf[i] <= o;
                    end
                end else begin
                    k_m[i] <= (k_m[i] >= beats[i]) ? -1 : k_m[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_u%0d", i), busy_w[i], k_m[i] >= 0);
            chk($sformatf("done_u%0d", i), done_w[i], k_m[i] == beats[i]);
            if (k_m[i] < 0 || k_m[i] == beats[i]) begin
                chk($sformatf("result_u%0d", i), res_w[i], m_res[i]);
                chk($sformatf("dot_u%0d", i), dot_w[i], m_dot[i]);
                chk($sformatf("ovf_u%0d", i), ovf_w[i], m_ovf[i]);
            end
        end
    end

    task automatic do_op(input string tag, input logic md, input logic st,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [VW-1:0] er, input logic [AW-1:0] ed, input logic eo);
        int lat [3];
        lat = '{0, 0, 0};
        @(posedge clk) #1;
        vector_a = a;
        vector_b = b;
        mode     = md;
        saturate = st;
        start    = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_w[i] && lat[i] == 0) lat[i] = k + 1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_latency_u%0d", tag, i), lat[i], lat_ref[i]);
            chk($sformatf("%s_result_u%0d", tag, i), res_w[i], er);
            chk($sformatf("%s_dot_u%0d", tag, i), dot_w[i], ed);
            chk($sformatf("%s_ovf_u%0d", tag, i), ovf_w[i], eo);
        end
    endtask

    logic [VW-1:0] ramp_a, ramp_b, ramp_p, f300, fmax;
    bit            seen;

    initial begin
        ramp_a = pack8('{1, 2, 3, 4, 5, 6, 7, 8});
        ramp_b = pack8('{8, 7, 6, 5, 4, 3, 2, 1});
        ramp_p = pack8('{8, 14, 18, 20, 20, 18, 14, 8});
        f300   = fill(300);
        fmax   = fill(65535);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", res_w[0], '0);
        chk("reset_dot", dot_w[0], '0);
        chk("reset_busy", busy_w[0], 1'b0);
        chk("reset_done", done_w[0], 1'b0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        do_op("ew_ramp",   1'b0, 1'b0, ramp_a, ramp_b, ramp_p, '0, 1'b0);
        do_op("dot_ramp",  1'b1, 1'b0, ramp_a, ramp_b, '0, 35'd120, 1'b0);
        do_op("ew300",     1'b0, 1'b0, f300, f300, fill(24464), '0, 1'b1);
        do_op("ew300_sat", 1'b0, 1'b1, f300, f300, fill(65535), '0, 1'b1);
        do_op("dot_max",   1'b1, 1'b0, fmax, fmax, '0, 35'd34358689800, 1'b0);

        // Start pulsed mid-operation with different operands must not disturb the running op.
        @(posedge clk) #1;
        vector_a = ramp_a; vector_b = ramp_b; mode = 1'b0; saturate = 1'b0; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0; vector_a = f300; vector_b = f300;
        @(posedge clk) #1;
        @(posedge clk) #1;
        mode = 1'b1; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("ignore_result_u0", res_w[0], ramp_p);
        chk("ignore_dot_u0", dot_w[0], '0);
        chk("ignore_result_u1", res_w[1], ramp_p);
        chk("ignore_dot_u2", dot_w[2], 35'd720000);

        // Reset while the LANES=2 instance is at beat 2.
        @(posedge clk) #1;
        vector_a = f300; vector_b = f300; mode = 1'b0; saturate = 1'b0; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        chk("abort_result", res_w[0], '0);
        chk("abort_ovf", ovf_w[0], 1'b0);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_done", done_w[0], 1'b0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        do_op("after_abort", 1'b0, 1'b0, ramp_a, ramp_b, ramp_p, '0, 1'b0);

        // Back-to-back: second start held from the done cycle so it is taken right after.
        @(posedge clk) #1;
        vector_a = ramp_a; vector_b = ramp_b; mode = 1'b0; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        chk("b2b_first_done_seen", seen, 1'b1);
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk) #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_dot_u0", dot_w[0], 35'd120);
        chk("b2b_result_u0", res_w[0], '0);

        do_op("ew_ramp_sat", 1'b0, 1'b1, ramp_a, ramp_b, ramp_p, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
